serial_adder: RTL

//  Parametrised bit-serial adder/subtractor; next generation of the 1-bit halfadder.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder_cell.sv | 28 ++
 rtl/serial_adder.sv | 118 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and its width.
package serial_adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder built from two half adders; the only arithmetic cell
// in the serial adder datapath.
module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  halfadder u_ha0 (.a(a),    .b(b),    .sum(w_s0), .carry(w_c0));
  halfadder u_ha1 (.a(w_s0), .b(c_in), .sum(sum),  .carry(w_c1));

  assign c_out = w_c0 | w_c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, registered carry,
// start/ready/done handshake with sum, carry-out and signed overflow.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  // Holds the WIDTH-1 result bits produced so far; the last bit goes straight to sum.
  logic [WIDTH-2:0]   r_res_sh;
  logic [WIDTH-2:0]   w_res_next;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_c_out;
  logic               r_ovf;
  logic               w_fa_sum;
  logic               w_fa_cout;
  logic               w_last;

  full_adder_cell u_fa (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .c_in  (r_carry),
    .sum   (w_fa_sum),
    .c_out (w_fa_cout)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_res_next            = r_res_sh >> 1;
    w_res_next[WIDTH-2]   = w_fa_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == IDLE);
    busy  = (r_state == RUN);
    done  = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_c_out  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtraction as a + ~b + 1: invert b and seed the carry with 1.
            r_a_sh   <= a;
            r_b_sh   <= sub ? ~b : b;
            r_carry  <= sub;
            r_res_sh <= '0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res_sh <= w_res_next;
          r_carry  <= w_fa_cout;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_sum   <= {w_fa_sum, r_res_sh};
            r_c_out <= w_fa_cout;
            // r_carry here is the carry into the MSB.
            r_ovf   <= r_carry ^ w_fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;
endmodule
